// File: rtl/timer_clint_mc.sv
// Multi-hart machine timer / software-interrupt block: shared prescaled 64-bit mtime, per-hart
// mtimecmp and msip. Optional macro TIMER_AUTORELOAD_EN adds per-hart period auto-reload.
module timer_clint_mc #(
  parameter int XLEN      = 32,
  parameter int NUM_HARTS = 4,
  parameter int PRESC_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [NUM_HARTS-1:0] int_timer,
  output logic [NUM_HARTS-1:0] int_soft,
  input  logic                 sel,
  input  logic [15:0]          addr,
  input  logic [3:0]           we,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      rdata
);

  localparam logic [13:0] W_CTRL  = 14'h2FFC;
  localparam logic [13:0] W_PRESC = 14'h2FFD;
  localparam logic [13:0] W_MTLO  = 14'h2FFE;
  localparam logic [13:0] W_MTHI  = 14'h2FFF;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [63:0]          mtime_r;
  logic [63:0]          mtime_nxt_s;
  logic [PRESC_W-1:0]   cnt_r;
  logic [PRESC_W-1:0]   cnt_nxt_s;
  logic [PRESC_W-1:0]   presc_r;
  logic                 en_r;
  logic [NUM_HARTS-1:0] msip_r;
  logic [63:0]          cmp_r     [NUM_HARTS];
  logic [63:0]          cmp_nxt_s [NUM_HARTS];
  logic [NUM_HARTS-1:0] int_timer_r;
  logic [NUM_HARTS-1:0] cmp_true_s;
  logic [NUM_HARTS-1:0] cmp_wr_s;
  logic [NUM_HARTS-1:0] msip_wr_s;
  logic [XLEN-1:0]      rdata_r;
  logic [XLEN-1:0]      rd_val_s;
  logic [XLEN-1:0]      ctrl_val_s;
  logic                 wr_s;
  logic                 rd_s;
  logic                 tick_s;
  logic                 unused_s;
`ifdef TIMER_AUTORELOAD_EN
  logic                 arl_r;
  logic [63:0]          per_r [NUM_HARTS];
  logic [NUM_HARTS-1:0] per_wr_s;
`endif

  assign wr_s     = sel && (we != 4'b0000);
  assign rd_s     = sel && (we == 4'b0000);
  assign tick_s   = en_r && (cnt_r == presc_r);
  assign unused_s = ^addr[1:0];

  // Per-hart address decode and live compare
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      msip_wr_s[h]  = wr_s && (addr[15:2] == 14'(h));
      cmp_wr_s[h]   = wr_s && (addr[15:14] == 2'b01) && (addr[13:3] == 11'(h));
      cmp_true_s[h] = (mtime_r >= cmp_r[h]);
`ifdef TIMER_AUTORELOAD_EN
      per_wr_s[h]   = wr_s && (addr[15:14] == 2'b10) && (addr[13:3] == 11'(h));
`endif
    end
  end

  // Prescaler counter next state; a PRESC write restarts the count
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (wr_s && (addr[15:2] == W_PRESC)) begin
      cnt_nxt_s = '0;
    end else if (tick_s) begin
      cnt_nxt_s = '0;
    end else if (en_r) begin
      cnt_nxt_s = cnt_r + PRESC_W'(1'b1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // mtime next state; a bus write owns its word and the other word is left untouched
  always_comb begin
    mtime_nxt_s = mtime_r + 64'(tick_s);
    if (wr_s && (addr[15:2] == W_MTLO)) begin
      mtime_nxt_s = {mtime_r[63:32], lane_merge(mtime_r[31:0], wdata, we)};
    end else if (wr_s && (addr[15:2] == W_MTHI)) begin
      mtime_nxt_s = {lane_merge(mtime_r[63:32], wdata, we), mtime_r[31:0]};
    end else begin
      mtime_nxt_s = mtime_r + 64'(tick_s);
    end
  end

  // mtimecmp next state; bus writes take priority over reload
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      cmp_nxt_s[h] = cmp_r[h];
      if (cmp_wr_s[h]) begin
        if (addr[2]) begin
          cmp_nxt_s[h] = {lane_merge(cmp_r[h][63:32], wdata, we), cmp_r[h][31:0]};
        end else begin
          cmp_nxt_s[h] = {cmp_r[h][63:32], lane_merge(cmp_r[h][31:0], wdata, we)};
        end
      end
`ifdef TIMER_AUTORELOAD_EN
      else if (arl_r && (per_r[h] != 64'd0) && cmp_true_s[h]) begin
        cmp_nxt_s[h] = cmp_r[h] + per_r[h];
      end
`endif
      else begin
        cmp_nxt_s[h] = cmp_r[h];
      end
    end
  end

  // Read mux; unmapped addresses read zero
  always_comb begin
`ifdef TIMER_AUTORELOAD_EN
    ctrl_val_s = {30'b0, arl_r, en_r};
`else
    ctrl_val_s = {31'b0, en_r};
`endif
    rd_val_s = '0;
    case (addr[15:2])
      W_CTRL:  rd_val_s = ctrl_val_s;
      W_PRESC: rd_val_s = XLEN'(presc_r);
      W_MTLO:  rd_val_s = mtime_r[31:0];
      W_MTHI:  rd_val_s = mtime_r[63:32];
      default: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          rd_val_s = rd_val_s | ((addr[15:2] == 14'(h)) ? {31'b0, msip_r[h]} : 32'h0);
          rd_val_s = rd_val_s | (((addr[15:14] == 2'b01) && (addr[13:3] == 11'(h))) ?
                                 (addr[2] ? cmp_r[h][63:32] : cmp_r[h][31:0]) : 32'h0);
`ifdef TIMER_AUTORELOAD_EN
          rd_val_s = rd_val_s | (((addr[15:14] == 2'b10) && (addr[13:3] == 11'(h))) ?
                                 (addr[2] ? per_r[h][63:32] : per_r[h][31:0]) : 32'h0);
`endif
        end
      end
    endcase
  end

  // Counter, control and timebase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_r <= 64'd0;
      cnt_r   <= '0;
      presc_r <= '0;
      en_r    <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      arl_r   <= 1'b0;
`endif
    end else begin
      mtime_r <= mtime_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (wr_s && (addr[15:2] == W_PRESC)) begin
        presc_r <= PRESC_W'(lane_merge(32'(presc_r), wdata, we));
      end
      if (wr_s && (addr[15:2] == W_CTRL) && we[0]) begin
        en_r  <= wdata[0];
`ifdef TIMER_AUTORELOAD_EN
        arl_r <= wdata[1];
`endif
      end
    end
  end

  // Per-hart registers and interrupt outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_r      <= '0;
      int_timer_r <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp_r[h] <= '1;
`ifdef TIMER_AUTORELOAD_EN
        per_r[h] <= 64'd0;
`endif
      end
    end else begin
      int_timer_r <= cmp_true_s;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp_r[h] <= cmp_nxt_s[h];
        if (msip_wr_s[h] && we[0]) begin
          msip_r[h] <= wdata[0];
        end
`ifdef TIMER_AUTORELOAD_EN
        if (per_wr_s[h]) begin
          if (addr[2]) begin
            per_r[h][63:32] <= lane_merge(per_r[h][63:32], wdata, we);
          end else begin
            per_r[h][31:0] <= lane_merge(per_r[h][31:0], wdata, we);
          end
        end
`endif
      end
    end
  end

  // Registered read data, held when no read is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (rd_s) begin
      rdata_r <= rd_val_s;
    end
  end

  assign int_timer = int_timer_r;
  assign int_soft  = msip_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_timer_clint_mc.sv
// Self-checking bench for timer_clint_mc: directed scenarios plus randomized compare/msip traffic.
module tb_timer_clint_mc;
  localparam int NH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NH-1:0] int_timer;
  logic [NH-1:0] int_soft;
  logic          sel = 1'b0;
  logic [15:0]   addr = 16'h0;
  logic [3:0]    we = 4'h0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_clint_mc #(.XLEN(32), .NUM_HARTS(NH), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .int_timer(int_timer), .int_soft(int_soft),
    .sel(sel), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata)
  );

  // Bus tasks start and end on a falling edge
  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    sel = 1'b1; addr = a; we = be; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 4'h0; wdata = 32'h0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; we = 4'h0;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    checks++; if (int_timer !== 4'h0 || int_soft !== 4'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got it=%h is=%h rd=%h exp 0", int_timer, int_soft, rdata); end
    rd(16'hBFF8, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mtime got=%h exp=0", v); end
    rd(16'h4000, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got=%h exp=ffffffff", v); end
    rd(16'hBFF0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(16'hBFF8, 4'hF, 32'h1234);
    wr(16'h4008, 4'hF, 32'h0);
    wr(16'h400C, 4'hF, 32'h0);
    wr(16'h0000, 4'hF, 32'h1);
    wr(16'hBFF0, 4'hF, 32'h1);
    repeat (5) @(negedge clk);
    rd(16'hBFF8, v);
    checks++; if (v !== 32'h1239) begin errors++; $display("FAIL mid_count got=%h exp=1239", v); end
    checks++; if (int_timer !== 4'b0010 || int_soft !== 4'b0001) begin
      errors++; $display("FAIL pre_reset_irq got it=%b is=%b exp 0010/0001", int_timer, int_soft); end
    #2 rst = 1'b1;
    #1;
    checks++; if (int_timer !== 4'h0 || int_soft !== 4'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset got it=%h is=%h rd=%h exp 0", int_timer, int_soft, rdata); end
    @(negedge clk);
    rst = 1'b0;
    rd(16'hBFF8, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL post_reset_mtime got=%h exp=0", v); end
    rd(16'h4008, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp got=%h exp=ffffffff", v); end
  endtask

  task automatic test_prescaler();
    logic [31:0] v;
    wr(16'hBFF4, 4'hF, 32'd3);
    wr(16'hBFF0, 4'hF, 32'h1);
    repeat (20) @(negedge clk);
    rd(16'hBFF8, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL presc3 got=%0d exp=5", v); end
    wr(16'hBFF0, 4'hF, 32'h0);
    wr(16'hBFF4, 4'hF, 32'd0);
    wr(16'hBFF8, 4'hF, 32'd0);
    wr(16'hBFF0, 4'hF, 32'h1);
    repeat (7) @(negedge clk);
    rd(16'hBFF8, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL presc0 got=%0d exp=7", v); end
    wr(16'hBFF0, 4'hF, 32'h0);
    repeat (10) @(negedge clk);
    rd(16'hBFF8, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL frozen got=%0d exp=9", v); end
  endtask

  task automatic test_carry_wrap();
    logic [31:0] lo, hi;
    wr(16'hBFF8, 4'hF, 32'hFFFF_FFFE);
    wr(16'hBFFC, 4'hF, 32'h0);
    wr(16'hBFF0, 4'hF, 32'h1);
    @(negedge clk);
    wr(16'hBFF0, 4'hF, 32'h0);
    rd(16'hBFFC, hi); rd(16'hBFF8, lo);
    checks++; if ({hi, lo} !== 64'h1_0000_0000) begin errors++; $display("FAIL carry got=%h%h exp=100000000", hi, lo); end
    wr(16'hBFF8, 4'hF, 32'hFFFF_FFFF);
    wr(16'hBFFC, 4'hF, 32'hFFFF_FFFF);
    wr(16'hBFF0, 4'hF, 32'h1);
    wr(16'hBFF0, 4'hF, 32'h0);
    rd(16'hBFFC, hi); rd(16'hBFF8, lo);
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL wrap got=%h%h exp=0", hi, lo); end
    // Write lands on a tick that would carry; the write must win with no carry into hi
    wr(16'hBFF8, 4'hF, 32'hFFFF_FFFF);
    wr(16'hBFF0, 4'hF, 32'h1);
    wr(16'hBFF8, 4'hF, 32'h10);
    wr(16'hBFF0, 4'hF, 32'h0);
    rd(16'hBFFC, hi); rd(16'hBFF8, lo);
    checks++; if ({hi, lo} !== 64'h11) begin errors++; $display("FAIL write_vs_tick got=%h%h exp=11", hi, lo); end
  endtask

  task automatic test_timer_irq();
    wr(16'hBFF8, 4'hF, 32'h0);
    wr(16'hBFFC, 4'hF, 32'h0);
    wr(16'h4010, 4'hF, 32'd100);
    wr(16'h4014, 4'hF, 32'h0);
    wr(16'hBFF0, 4'hF, 32'h1);
    repeat (100) @(negedge clk);
    checks++; if (int_timer !== 4'b0000) begin errors++; $display("FAIL irq_early got=%b exp=0000", int_timer); end
    @(negedge clk);
    checks++; if (int_timer !== 4'b0100) begin errors++; $display("FAIL irq_set got=%b exp=0100", int_timer); end
    wr(16'h4010, 4'hF, 32'd200);
    checks++; if (int_timer !== 4'b0100) begin errors++; $display("FAIL irq_hold got=%b exp=0100", int_timer); end
    @(negedge clk);
    checks++; if (int_timer !== 4'b0000) begin errors++; $display("FAIL irq_clear got=%b exp=0000", int_timer); end
    wr(16'hBFF0, 4'hF, 32'h0);
  endtask

  task automatic test_msip_lanes();
    logic [31:0] v;
    wr(16'h000C, 4'hF, 32'h1);
    checks++; if (int_soft !== 4'b1000) begin errors++; $display("FAIL msip3 got=%b exp=1000", int_soft); end
    rd(16'h000C, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL msip3_rd got=%h exp=1", v); end
    wr(16'h000C, 4'hF, 32'hFFFF_FFFE);
    wr(16'h0014, 4'hF, 32'h1);
    checks++; if (int_soft !== 4'b0000) begin errors++; $display("FAIL msip_clr got=%b exp=0000", int_soft); end
    rd(16'h0014, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_hart got=%h exp=0", v); end
    wr(16'hBFF4, 4'hF, 32'h1234);
    wr(16'hBFF4, 4'b0010, 32'h0000_0100);
    rd(16'hBFF4, v);
    checks++; if (v !== 32'h0134) begin errors++; $display("FAIL presc_lane got=%h exp=0134", v); end
    wr(16'hBFF4, 4'hF, 32'h0);
    rd(16'h1230, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=0", v); end
  endtask

  task automatic test_random();
    logic [63:0] m_cmp [NH];
    logic [63:0] m_mtime;
    logic [NH-1:0] m_msip;
    logic [NH-1:0] exp_irq;
    logic [31:0] lo, hi, d;
    logic [3:0] be;
    int h;
    m_mtime = 64'h0;
    m_msip = 4'h0;
    for (int g = 0; g < NH; g++) begin
      m_cmp[g] = {$urandom, $urandom};
      wr(16'h4004 + 16'(8*g), 4'hF, m_cmp[g][63:32]);
      wr(16'h4000 + 16'(8*g), 4'hF, m_cmp[g][31:0]);
      wr(16'(4*g), 4'hF, 32'h0);
    end
    for (int it = 0; it < 30; it++) begin
      h = $urandom_range(NH-1, 0);
      m_cmp[h] = {$urandom, $urandom};
      case ($urandom_range(3, 0))
        0: m_mtime = m_cmp[h];
        1: m_mtime = m_cmp[h] + 64'($urandom_range(3, 0));
        2: m_mtime = m_cmp[h] - 64'($urandom_range(3, 0));
        default: m_mtime = {$urandom, $urandom};
      endcase
      wr(16'h4004 + 16'(8*h), 4'hF, m_cmp[h][63:32]);
      wr(16'h4000 + 16'(8*h), 4'hF, m_cmp[h][31:0]);
      wr(16'hBFFC, 4'hF, m_mtime[63:32]);
      wr(16'hBFF8, 4'hF, m_mtime[31:0]);
      be = 4'($urandom_range(15, 1));
      d = $urandom;
      if (be[0]) m_msip[h] = d[0];
      wr(16'(4*h), be, d);
      @(negedge clk);
      for (int g = 0; g < NH; g++) exp_irq[g] = (m_mtime >= m_cmp[g]);
      checks++; if (int_timer !== exp_irq) begin
        errors++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, int_timer, exp_irq); end
      checks++; if (int_soft !== m_msip) begin
        errors++; $display("FAIL rand_msip it=%0d got=%b exp=%b", it, int_soft, m_msip); end
      rd(16'h4000 + 16'(8*h), lo);
      rd(16'h4004 + 16'(8*h), hi);
      checks++; if ({hi, lo} !== m_cmp[h]) begin
        errors++; $display("FAIL rand_cmp it=%0d got=%h%h exp=%h", it, hi, lo, m_cmp[h]); end
    end
  endtask

`ifdef TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [31:0] v;
    logic exp_p;
    int period;
    period = 10;
    wr(16'hBFF0, 4'hF, 32'h0);
    wr(16'hBFF4, 4'hF, 32'h0);
    wr(16'hBFF8, 4'hF, 32'h0);
    wr(16'hBFFC, 4'hF, 32'h0);
    wr(16'h8000, 4'hF, 32'(period));
    wr(16'h8004, 4'hF, 32'h0);
    wr(16'h4000, 4'hF, 32'(period));
    wr(16'h4004, 4'hF, 32'h0);
    wr(16'hBFF0, 4'hF, 32'h3);
    // mtime equals k-1 before edge k; a match at mtime n*period shows one cycle later
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      exp_p = ((k - 1) >= period) && ((k - 1) <= 3 * period) && (((k - 1) % period) == 0);
      checks++; if (int_timer[0] !== exp_p) begin
        errors++; $display("FAIL arl_pulse k=%0d got=%b exp=%b", k, int_timer[0], exp_p); end
    end
    wr(16'hBFF0, 4'hF, 32'h2);
    rd(16'h4000, v);
    checks++; if (v !== 32'd40) begin errors++; $display("FAIL arl_cmp got=%0d exp=40", v); end
    rd(16'hBFF0, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL arl_ctrl got=%h exp=2", v); end
  endtask
`else
  task automatic test_autoreload();
    logic [31:0] v;
    wr(16'h8000, 4'hF, 32'h5);
    rd(16'h8000, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL period_absent got=%h exp=0", v); end
    wr(16'hBFF0, 4'hF, 32'h2);
    rd(16'hBFF0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL arl_absent got=%h exp=0", v); end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_reset_mid();
    test_prescaler();
    test_carry_wrap();
    test_timer_irq();
    test_msip_lanes();
    test_random();
    test_autoreload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
